// File: rtl/calc_sequencer.sv
// calc_sequencer: pushbutton-driven control sequencer for a simple calculator.
// One button steps through: enter A -> latch A -> enter B -> latch B ->
// execute -> show result (or error) -> back to enter A.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-low reset
//   button       raw pushbutton, asynchronous, active-low (0 = pressed)
//   alu_done     arithmetic unit result valid
//   alu_err      arithmetic unit error, only meaningful with alu_done
//   load_a       one-cycle strobe, load operand A
//   load_b       one-cycle strobe, load operand B
//   alu_start    one-cycle strobe, start the operation
//   load_r       one-cycle strobe, load the result register
//   clear_input  one-cycle strobe, clear the keypad entry unit
//   toggle       display select: 0 keypad entry, 1 result
//   error        high while in the error state
//   state        current state code (debug / LEDs)
module calc_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       load_a,
  output logic       load_b,
  output logic       alu_start,
  output logic       load_r,
  output logic       clear_input,
  output logic       toggle,
  output logic       error,
  output logic [2:0] state
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    LATCH_A = 3'd1,
    ENTER_B = 3'd2,
    LATCH_B = 3'd3,
    EXEC    = 3'd4,
    SHOW    = 3'd5,
    ERR     = 3'd6
  } state_e;

  // ---------------------------------------------------------------------------
  // Button conditioning: synchronizer, debouncer, press detector
  // ---------------------------------------------------------------------------
  logic            sync1_q, sync2_q;
  logic            vld1_q, vld2_q;
  logic            armed_q, armed_d;
  logic            db_level_q, db_level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;

  // The synchronizer resets to "released", which is not a real observation of
  // the button. vld1/vld2 mark when sync2 carries a genuine sample; press
  // events are only armed after a genuine released sample has been seen, so a
  // button held through reset never produces a press on its own.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    press_d    = 1'b0;
    armed_d    = armed_q | (vld2_q & sync2_q);
    if (sync2_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d   = '0;
      db_level_d = sync2_q;
      press_d    = ~sync2_q & armed_q;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      vld1_q     <= 1'b0;
      vld2_q     <= 1'b0;
      armed_q    <= 1'b0;
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= button;
      sync2_q    <= sync1_q;
      vld1_q     <= 1'b1;
      vld2_q     <= vld1_q;
      armed_q    <= armed_d;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic            load_a_q, load_a_d;
  logic            load_b_q, load_b_d;
  logic            start_q, start_d;
  logic            load_r_q, load_r_d;
  logic            clear_q, clear_d;
  logic            toggle_q, toggle_d;
  logic            error_q, error_d;
  logic            ack_clr;

  // All outputs are computed from the state being entered and registered on
  // the same edge as the transition, so each strobe is high exactly during
  // the first cycle of the state that produced it.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    ack_clr  = 1'b0;
    load_r_d = 1'b0;
    case (state_q)
      ENTER_A: if (press_q) state_d = LATCH_A;
      LATCH_A: state_d = ENTER_B;
      ENTER_B: if (press_q) state_d = LATCH_B;
      LATCH_B: begin
        state_d = EXEC;
        tmo_d   = '0;
      end
      EXEC: begin
        if (alu_done) begin
          if (alu_err) begin
            state_d = ERR;
          end else begin
            state_d  = SHOW;
            load_r_d = 1'b1;
          end
        end else if (tmo_q == TO_LAST) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SHOW, ERR: begin
        if (press_q) begin
          state_d = ENTER_A;
          ack_clr = 1'b1;
        end
      end
      default: state_d = ENTER_A;
    endcase

    load_a_d = (state_d == LATCH_A);
    load_b_d = (state_d == LATCH_B);
    start_d  = (state_d == EXEC) && (state_q != EXEC);
    clear_d  = ack_clr | load_a_d | load_b_d;
    toggle_d = (state_d == SHOW) || (state_d == ERR);
    error_d  = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ENTER_A;
      tmo_q    <= '0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      start_q  <= 1'b0;
      load_r_q <= 1'b0;
      clear_q  <= 1'b0;
      toggle_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      load_a_q <= load_a_d;
      load_b_q <= load_b_d;
      start_q  <= start_d;
      load_r_q <= load_r_d;
      clear_q  <= clear_d;
      toggle_q <= toggle_d;
      error_q  <= error_d;
    end
  end

  assign load_a      = load_a_q;
  assign load_b      = load_b_q;
  assign alu_start   = start_q;
  assign load_r      = load_r_q;
  assign clear_input = clear_q;
  assign toggle      = toggle_q;
  assign error       = error_q;
  assign state       = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer with short debounce/timeout parameters.
// A cycle-level behavioural reference model runs alongside the DUT; outputs
// are compared every cycle, plus directed checks of the key scenarios.
module tb_calc_sequencer;

  localparam int DEB = 4;
  localparam int TMO = 8;

  localparam int S_ENTER_A = 0;
  localparam int S_LATCH_A = 1;
  localparam int S_ENTER_B = 2;
  localparam int S_LATCH_B = 3;
  localparam int S_EXEC    = 4;
  localparam int S_SHOW    = 5;
  localparam int S_ERR     = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b1;
  logic       alu_done = 1'b0;
  logic       alu_err = 1'b0;
  logic       load_a, load_b, alu_start, load_r, clear_input, toggle, error;
  logic [2:0] state;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int          c_la, c_lb, c_start, c_lr, c_clr;

  calc_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button     (button),
    .alu_done   (alu_done),
    .alu_err    (alu_err),
    .load_a     (load_a),
    .load_b     (load_b),
    .alu_start  (alu_start),
    .load_r     (load_r),
    .clear_input(clear_input),
    .toggle     (toggle),
    .error      (error),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    c_la = 0; c_lb = 0; c_start = 0; c_lr = 0; c_clr = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // Button path: a two-deep sample queue (entries 2 = reset filler, counts as
  // released but is not a real observation), a run-length of equal levels,
  // and the press rule. Sequencer: state as a number, outputs derived from
  // the state being entered, timeout from the cycle number of EXEC entry.
  // ---------------------------------------------------------------------------
  int          pipe[$];
  int          smp, lvl, nxt;
  int          m_level, m_prev, m_run, m_state;
  bit          m_armed, m_press, m_valid, fire, give_clr, give_lr;
  bit          m_la, m_lb, m_st, m_lr, m_clr, m_tog, m_err;
  int unsigned cyc = 0;
  int unsigned exec_t0 = 0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_valid = 1'b1;
      m_state = S_ENTER_A;
      {m_la, m_lb, m_st, m_lr, m_clr, m_tog, m_err} = '0;
      pipe    = '{2, 2};
      m_level = 1;
      m_prev  = 1;
      m_run   = 0;
      m_armed = 1'b0;
      m_press = 1'b0;
    end else if (m_valid) begin
      nxt      = m_state;
      give_clr = 1'b0;
      give_lr  = 1'b0;
      case (m_state)
        S_ENTER_A: if (m_press) nxt = S_LATCH_A;
        S_LATCH_A: nxt = S_ENTER_B;
        S_ENTER_B: if (m_press) nxt = S_LATCH_B;
        S_LATCH_B: begin
          nxt     = S_EXEC;
          exec_t0 = cyc;
        end
        S_EXEC: begin
          if (alu_done) begin
            nxt     = alu_err ? S_ERR : S_SHOW;
            give_lr = !alu_err;
          end else if (cyc - exec_t0 >= TMO) begin
            nxt = S_ERR;
          end
        end
        default: begin
          if (m_press) begin
            nxt      = S_ENTER_A;
            give_clr = 1'b1;
          end
        end
      endcase
      m_la    = (nxt == S_LATCH_A);
      m_lb    = (nxt == S_LATCH_B);
      m_st    = (nxt == S_EXEC) && (m_state != S_EXEC);
      m_lr    = give_lr;
      m_clr   = give_clr || m_la || m_lb;
      m_tog   = (nxt == S_SHOW) || (nxt == S_ERR);
      m_err   = (nxt == S_ERR);
      m_state = nxt;

      smp = pipe.pop_front();
      pipe.push_back(button ? 1 : 0);
      lvl = (smp == 0) ? 0 : 1;
      if (lvl == m_prev) m_run++;
      else m_run = 1;
      m_prev = lvl;
      fire = 1'b0;
      if (m_run >= DEB && lvl != m_level) begin
        m_level = lvl;
        fire    = (lvl == 0) && m_armed;
      end
      if (smp == 1) m_armed = 1'b1;
      m_press = fire;
    end
  end

  // Lockstep comparison and strobe counting, away from the active edge.
  always @(negedge clk) begin
    #1;
    if (m_valid) begin
      check("state", 32'(state), 32'(m_state));
      check("outputs", 32'({load_a, load_b, alu_start, load_r, clear_input, toggle, error}),
            32'({m_la, m_lb, m_st, m_lr, m_clr, m_tog, m_err}));
    end
    if (load_a === 1'b1)      c_la++;
    if (load_b === 1'b1)      c_lb++;
    if (alu_start === 1'b1)   c_start++;
    if (load_r === 1'b1)      c_lr++;
    if (clear_input === 1'b1) c_clr++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int hold_left = 0;

  initial begin
    clear_counts();
    reset = 1'b0; button = 1'b1;
    tick(3);
    check("reset_state", 32'(state), S_ENTER_A);
    check("reset_outputs", 32'({load_a, load_b, alu_start, load_r, clear_input, toggle, error}), 0);
    reset = 1'b1;
    tick(4);

    // Clean press held 10 cycles in ENTER_A: one press, 0 -> 1 -> 2.
    clear_counts();
    button = 1'b0;
    tick(6); check("r036_wait", 32'(state), S_ENTER_A);
    tick(1); check("r036_latch_a", 32'(state), S_LATCH_A);
    check("r036_load_a", 32'(load_a), 1);
    check("r036_clear", 32'(clear_input), 1);
    tick(1); check("r036_enter_b", 32'(state), S_ENTER_B);
    check("r036_load_a_low", 32'(load_a), 0);
    tick(2);
    button = 1'b1;
    tick(8);
    check("r036_state_hold", 32'(state), S_ENTER_B);
    check("r036_load_a_count", 32'(c_la), 1);
    check("r036_clear_count", 32'(c_clr), 1);

    // Bounce 0,1,0,1 then stable 0; then EXEC with alu_done 3 cycles later.
    clear_counts();
    button = 1'b0; tick(1); button = 1'b1; tick(1);
    button = 1'b0; tick(1); button = 1'b1; tick(1);
    button = 1'b0;
    tick(6); check("r037_hold", 32'(state), S_ENTER_B);
    tick(1); check("r037_latch_b", 32'(state), S_LATCH_B);
    check("r037_load_b", 32'(load_b), 1);
    tick(1); check("r038_exec", 32'(state), S_EXEC);
    check("r038_start", 32'(alu_start), 1);
    tick(3); alu_done = 1'b1;
    tick(1); alu_done = 1'b0;
    check("r038_show", 32'(state), S_SHOW);
    check("r038_load_r", 32'(load_r), 1);
    check("r038_toggle", 32'(toggle), 1);
    tick(2);
    check("r037_load_b_count", 32'(c_lb), 1);
    check("r038_start_count", 32'(c_start), 1);
    check("r038_load_r_count", 32'(c_lr), 1);
    button = 1'b1; tick(8);
    button = 1'b0; tick(7);
    check("r038_back", 32'(state), S_ENTER_A);
    check("r038_clear", 32'(clear_input), 1);
    check("r038_toggle_off", 32'(toggle), 0);
    tick(1); button = 1'b1; tick(8);

    // Error result from the ALU.
    clear_counts();
    button = 1'b0; tick(8); button = 1'b1; tick(8);
    button = 1'b0; tick(8);
    check("r039_exec", 32'(state), S_EXEC);
    button = 1'b1;
    tick(1); alu_done = 1'b1; alu_err = 1'b1;
    tick(1); alu_done = 1'b0; alu_err = 1'b0;
    check("r039_err", 32'(state), S_ERR);
    check("r039_error", 32'(error), 1);
    check("r039_toggle", 32'(toggle), 1);
    tick(8);
    check("r039_no_load_r", 32'(c_lr), 0);
    button = 1'b0; tick(7);
    check("r039_back", 32'(state), S_ENTER_A);
    check("r039_error_off", 32'(error), 0);
    tick(1); button = 1'b1; tick(8);

    // Timeout, with a fresh press landing during EXEC.
    button = 1'b0; tick(8); button = 1'b1; tick(8);
    button = 1'b0; tick(5);
    button = 1'b1; tick(3);
    check("r040_exec_entry", 32'(state), S_EXEC);
    tick(1); button = 1'b0;
    tick(6); check("r040_still_exec", 32'(state), S_EXEC);
    tick(1); check("r040_err", 32'(state), S_ERR);
    tick(6); check("r040_no_queue", 32'(state), S_ERR);
    button = 1'b1; tick(8);
    button = 1'b0; tick(8); button = 1'b1; tick(8);
    check("r040_back", 32'(state), S_ENTER_A);

    // alu_done on the alu_start cycle.
    clear_counts();
    button = 1'b0; tick(8); button = 1'b1; tick(8);
    button = 1'b0; tick(8);
    alu_done = 1'b1;
    tick(1); alu_done = 1'b0;
    check("r028_min_dwell", 32'(state), S_SHOW);
    check("r028_load_r", 32'(load_r), 1);
    button = 1'b1; tick(8);
    button = 1'b0; tick(8); button = 1'b1; tick(8);

    // Reset mid-EXEC with the button held.
    button = 1'b0; tick(8); button = 1'b1; tick(8);
    button = 1'b0; tick(8);
    check("r041_exec", 32'(state), S_EXEC);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("r041_state", 32'(state), S_ENTER_A);
    check("r041_outputs", 32'({load_a, load_b, alu_start, load_r, clear_input, toggle, error}), 0);
    tick(1); reset = 1'b1;
    tick(12);
    check("r041_no_press", 32'(state), S_ENTER_A);
    button = 1'b1; tick(8);
    button = 1'b0; tick(8);
    check("r041_repress", 32'(state), S_ENTER_B);
    button = 1'b1; tick(8);

    // Randomized traffic, including bounces, stray alu_done and resets.
    for (int i = 0; i < 2000; i++) begin
      if (hold_left == 0) begin
        button    = ~button;
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      alu_done = ($urandom_range(0, 9) == 0);
      alu_err  = ($urandom_range(0, 2) == 0);
      reset    = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    reset = 1'b1; alu_done = 1'b0; alu_err = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
